// File: rtl/add_stream_pkg.sv
// Shared types and the saturating add function for the add_stream unit.
// The function is written at a fixed maximum width so any operand width up to ADD_MAX_W can use it.
package add_stream_pkg;

  localparam int ADD_MAX_W = 32;

  typedef enum logic [1:0] {
    ADD_WRAP = 2'b00,
    ADD_USAT = 2'b01,
    ADD_SSAT = 2'b10
  } add_mode_t;

  typedef struct packed {
    logic [ADD_MAX_W-1:0] sum;
    logic                 cout;
    logic                 ovf;
  } add_result_t;

  // width selects the live operand bits; mode 2'b11 falls through to wrap.
  function automatic add_result_t add_compute(input logic [ADD_MAX_W-1:0] a,
                                              input logic [ADD_MAX_W-1:0] b,
                                              input logic                 cin,
                                              input logic [1:0]           mode,
                                              input int                   width);
    add_result_t          r;
    logic [ADD_MAX_W:0]   raw;
    logic [ADD_MAX_W-1:0] mask;
    logic [ADD_MAX_W-1:0] top;
    logic                 a_msb;
    logic                 b_msb;
    logic                 r_msb;
    mask = '1;
    if (width < ADD_MAX_W) mask = mask >> (ADD_MAX_W - width);
    top    = mask ^ (mask >> 1);
    raw    = {1'b0, a & mask} + {1'b0, b & mask} + {{ADD_MAX_W{1'b0}}, cin};
    a_msb  = |(a & top);
    b_msb  = |(b & top);
    r_msb  = |(raw[ADD_MAX_W-1:0] & top);
    r.cout = |(raw & ({1'b0, mask} + {{ADD_MAX_W{1'b0}}, 1'b1}));
    r.ovf  = (a_msb == b_msb) && (r_msb != a_msb);
    r.sum  = raw[ADD_MAX_W-1:0] & mask;
    case (mode)
      ADD_USAT: if (r.cout) r.sum = mask;
      ADD_SSAT: if (r.ovf) r.sum = a_msb ? top : (mask >> 1);
      default: ;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/add_stream_fifo.sv
// First-word fall-through FIFO; when empty the output holds the last popped word.
module add_stream_fifo
  import add_stream_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       valid,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [WIDTH-1:0] last_q;
  logic             do_push;
  logic             do_pop;

  assign valid   = (count != '0);
  assign do_pop  = pop && valid;
  assign do_push = push && ((count < CW'(DEPTH)) || do_pop);
  assign dout    = valid ? mem[rd_ptr] : last_q;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap explicitly so non-power-of-two depths work.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      last_q <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == PW'(DEPTH-1)) ? '0 : wr_ptr + PW'(1);
      if (do_pop) begin
        rd_ptr <= (rd_ptr == PW'(DEPTH-1)) ? '0 : rd_ptr + PW'(1);
        last_q <= mem[rd_ptr];
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/add_stream_unit.sv
// Pipelined saturating adder with a credit-guarded result FIFO.
// Handshake: a beat transfers on a rising edge where valid && ready; ready never depends on valid.
module add_stream_unit
  import add_stream_pkg::*;
#(
  parameter int ADD_WIDTH   = 4,
  parameter int PIPE_STAGES = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [ADD_WIDTH-1:0]            a,
  input  logic [ADD_WIDTH-1:0]            b,
  input  logic                            cin,
  input  logic [1:0]                      mode,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [ADD_WIDTH-1:0]            sum,
  output logic                            cout,
  output logic                            ovf,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level
);
  localparam int LW = $clog2(FIFO_DEPTH+1);
  localparam int CW = LW + 1;
  localparam int DW = ADD_WIDTH + 2;

  add_result_t            res;
  logic                   accept;
  logic                   push;
  logic [LW-1:0]          inflight;
  logic [CW-1:0]          credit_used;
  logic [PIPE_STAGES-1:0] pvalid;
  logic [DW-1:0]          pdata [PIPE_STAGES];
  logic [DW-1:0]          fifo_dout;

  assign res    = add_compute(ADD_MAX_W'(a), ADD_MAX_W'(b), cin, mode, ADD_WIDTH);
  assign accept = in_valid && in_ready;
  assign push   = pvalid[PIPE_STAGES-1];

  generate
    if (ADD_WIDTH < ADD_MAX_W) begin : g_hi
      logic unused_sum_hi;
      assign unused_sum_hi = ^res.sum[ADD_MAX_W-1:ADD_WIDTH];
    end
  endgenerate

  // Every accepted beat owns a FIFO slot from accept until pop, so the FIFO can never overflow.
  assign credit_used = CW'(fifo_level) + CW'(inflight);
  assign in_ready    = rst && (credit_used < CW'(FIFO_DEPTH));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pvalid   <= '0;
      inflight <= '0;
      for (int i = 0; i < PIPE_STAGES; i++) pdata[i] <= '0;
    end else begin
      pvalid[0] <= accept;
      pdata[0]  <= {res.sum[ADD_WIDTH-1:0], res.cout, res.ovf};
      for (int i = 1; i < PIPE_STAGES; i++) begin
        pvalid[i] <= pvalid[i-1];
        pdata[i]  <= pdata[i-1];
      end
      case ({accept, push})
        2'b10:   inflight <= inflight + LW'(1);
        2'b01:   inflight <= inflight - LW'(1);
        default: ;
      endcase
    end
  end

  add_stream_fifo #(
    .WIDTH (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (pdata[PIPE_STAGES-1]),
    .pop   (out_ready),
    .dout  (fifo_dout),
    .valid (out_valid),
    .count (fifo_level)
  );

  assign sum  = fifo_dout[DW-1:2];
  assign cout = fifo_dout[1];
  assign ovf  = fifo_dout[0];

endmodule
